// File: rtl/demux_1_4_rr_sched_if.sv
// Handshake and bus bundle for the 1-to-4 round-robin demux scheduler.
// DEMUX_SCHED_STATS_EN adds the statistics select/readback pair.
interface demux_1_4_rr_sched_if #(
    parameter int WIDTH = 1
);
    logic [3:0]       en_mask;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic [1:0]       sel;
    logic [WIDTH-1:0] y0;
    logic [WIDTH-1:0] y1;
    logic [WIDTH-1:0] y2;
    logic [WIDTH-1:0] y3;
    logic [3:0]       y_valid;
    logic [3:0]       y_ready;
    logic             busy;
`ifdef DEMUX_SCHED_STATS_EN
    logic [1:0]       stat_sel;
    logic [15:0]      stat_count;

    modport slave (
        input  en_mask, in_valid, in_data, y_ready, stat_sel,
        output in_ready, sel, y0, y1, y2, y3, y_valid, busy, stat_count
    );

    modport master (
        output en_mask, in_valid, in_data, y_ready, stat_sel,
        input  in_ready, sel, y0, y1, y2, y3, y_valid, busy, stat_count
    );
`else
    modport slave (
        input  en_mask, in_valid, in_data, y_ready,
        output in_ready, sel, y0, y1, y2, y3, y_valid, busy
    );

    modport master (
        output en_mask, in_valid, in_data, y_ready,
        input  in_ready, sel, y0, y1, y2, y3, y_valid, busy
    );
`endif
endinterface

// File: rtl/demux_1_4_rr_sched.sv
// One-item holding buffer steered round-robin to four destinations in bursts, skipping masked ones.
// Optional per-destination delivery counters are enabled by DEMUX_SCHED_STATS_EN.
module demux_1_4_rr_sched #(
    parameter int WIDTH = 1,
    parameter int BURST = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    demux_1_4_rr_sched_if.slave  bus
);

    localparam int                CNT_W    = (BURST > 1) ? $clog2(BURST) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(BURST - 1);
    localparam logic [0:0]        ST_IDLE  = 1'b0;
    localparam logic [0:0]        ST_HOLD  = 1'b1;

    logic [0:0]       r_state;
    logic [1:0]       r_ptr;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_data;

    logic       w_hold;
    logic       w_fire;
    logic       w_any_en;
    logic       w_in_ready;
    logic       w_accept;
    logic       w_mask_move;
    logic [1:0] w_next_ptr;
    logic [1:0] w_idx;
    logic       w_found;

    assign w_hold      = (r_state == ST_HOLD);
    assign w_any_en    = |bus.en_mask;
    assign w_fire      = w_hold & bus.y_ready[r_ptr] & bus.en_mask[r_ptr];
    assign w_in_ready  = !rst & w_any_en & (!w_hold | w_fire);
    assign w_accept    = bus.in_valid & w_in_ready;
    assign w_mask_move = w_any_en & !bus.en_mask[r_ptr];

    // First enabled index strictly after r_ptr; the +4 step lets a lone enabled ptr pick itself.
    always_comb begin
        w_next_ptr = r_ptr;
        w_found    = 1'b0;
        w_idx      = r_ptr;
        for (int k = 1; k <= 4; k++) begin
            w_idx = r_ptr + 2'(k);
            if (!w_found && bus.en_mask[w_idx]) begin
                w_next_ptr = w_idx;
                w_found    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_ptr   <= 2'd0;
            r_cnt   <= '0;
            r_data  <= '0;
        end else begin
            if (w_accept) begin
                r_state <= ST_HOLD;
                r_data  <= bus.in_data;
            end else if (w_fire) begin
                r_state <= ST_IDLE;
            end

            // Fire and mask-move are exclusive because fire needs en_mask[r_ptr] set.
            if (w_fire) begin
                if (r_cnt == CNT_LAST) begin
                    r_cnt <= '0;
                    r_ptr <= w_next_ptr;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else if (w_mask_move) begin
                r_ptr <= w_next_ptr;
                r_cnt <= '0;
            end
        end
    end

    always_comb begin
        bus.y0 = '0;
        bus.y1 = '0;
        bus.y2 = '0;
        bus.y3 = '0;
        case (r_ptr)
            2'd0:    bus.y0 = r_data;
            2'd1:    bus.y1 = r_data;
            2'd2:    bus.y2 = r_data;
            default: bus.y3 = r_data;
        endcase
    end

    assign bus.y_valid  = {3'b000, w_hold} << r_ptr;
    assign bus.sel      = r_ptr;
    assign bus.busy     = w_hold;
    assign bus.in_ready = w_in_ready;

`ifdef DEMUX_SCHED_STATS_EN
    logic [15:0] r_stat [4];

    // Per-destination delivery counters saturate rather than wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int n = 0; n < 4; n++) begin
                r_stat[n] <= 16'd0;
            end
        end else if (w_fire && (r_stat[r_ptr] != 16'hFFFF)) begin
            r_stat[r_ptr] <= r_stat[r_ptr] + 16'd1;
        end
    end

    assign bus.stat_count = r_stat[bus.stat_sel];
`endif

endmodule
